// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory over req/ack, holds the returned word and offers it downstream with
// valid/ready. Taken-branch redirects reload the PC and squash pending work.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [5:0]            funct,
  output logic [15:0]           imm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  fetch_done;

  // Redirect targets are word aligned; the low two address bits are dropped.
  assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

  // A fetch completes only when memory answers and no redirect discards it.
  assign fetch_done = (state == S_WAIT) && imem_ack && !redirect_valid;

  // State register with synchronous reset.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: redirect always lands in WAIT; ready only drains HOLD.
  // NOTE: state_next gets a default before the case so no latch is inferred
  // for paths that leave it unassigned.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_WAIT;
      S_WAIT: begin
        if (redirect_valid)  state_next = S_WAIT;
        else if (imem_ack)   state_next = S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid || instr_ready) state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: request and valid come straight from the state register.
  always_comb begin
    imem_req    = (state == S_WAIT);
    instr_valid = (state == S_HOLD);
  end

  // PC and instruction register updates; reset beats redirect beats capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_target;
    end else if (fetch_done) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
      pc       <= pc + ADDR_WIDTH'(PC_STEP);
    end
  end

  assign imem_addr = pc;

  // Field slices of the held instruction, fixed MIPS encoding.
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run compared against a transaction-level model of the fetch behaviour.
module tb_instr_fetch;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    funct;
  logic [15:0]   imm;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (32'h0000_0000),
    .PC_STEP   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .funct         (funct),
    .imm           (imm)
  );

  always #5 clk = ~clk;

  // Memory contents derived from the address so each fetch is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Advance one clock and land on the following falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, release, and end on a falling edge with the DUT in its first WAIT.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    imem_rdata = '0; redirect_pc = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    n_checks++;
    if (imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 00000000", imem_addr);
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid);
    end
    n_checks++;
    if ({instr, instr_pc} !== 64'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc);
    end
    n_checks++;
    if ({opcode, rs, rt, rd, funct, imm} !== 43'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {opcode, rs, rt, rd, funct, imm});
    end
    // Still in IDLE while reset is released: no request yet.
    rst = 1'b0; imem_ack = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_addr;
    logic [31:0] exp_ipc;
    exp_addr = 32'h0;
    exp_ipc  = 32'h0;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (instr_valid !== k[0] || imem_req !== !k[0]) begin
        n_fail++; $display("FAIL zw_pulse[%0d]: got valid=%b req=%b want %b/%b", k, instr_valid, imem_req, k[0], !k[0]);
      end
      if (k[0] == 1'b0) begin
        n_checks++;
        if (imem_addr !== exp_addr) begin
          n_fail++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, exp_addr);
        end
        imem_ack = 1'b1; imem_rdata = mem_word(exp_addr);
        exp_addr += 4;
      end else begin
        n_checks++;
        if (instr_pc !== exp_ipc || instr !== mem_word(exp_ipc)) begin
          n_fail++; $display("FAIL zw_instr[%0d]: got %h@%h want %h@%h", k, instr, instr_pc, mem_word(exp_ipc), exp_ipc);
        end
        imem_ack = 1'b0;
        exp_ipc += 4;
      end
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_lw_hold_stall();
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // ack outside WAIT is ignored
    n_checks++;
    if (opcode !== 6'b100011 || rs !== 5'd1 || rt !== 5'd2 || imm !== 16'h0010 ||
        rd !== 5'd0 || funct !== 6'h10) begin
      n_fail++; $display("FAIL lw_fields: got op=%h rs=%0d rt=%0d rd=%0d fn=%h imm=%h want 23/1/2/0/10/0010",
                         opcode, rs, rt, rd, funct, imm);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h8C22_0010 ||
          imem_addr !== 32'h4) begin
        n_fail++; $display("FAIL hold_stall[%0d]: got v=%b req=%b instr=%h addr=%h want 1/0/8c220010/00000004",
                           k, instr_valid, imem_req, instr, imem_addr);
      end
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL hold_release: got v=%b req=%b addr=%h want 0/1/00000004", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_delayed_ack();
    int req_cycles;
    req_cycles = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (imem_req === 1'b1 && imem_addr === 32'h0) req_cycles++;
      imem_ack = (k == 3); imem_rdata = mem_word(32'h0);
      tick();
    end
    imem_ack = 1'b0;
    n_checks++;
    if (req_cycles != 4) begin
      n_fail++; $display("FAIL delay_req_cycles: got %0d want 4", req_cycles);
    end
    n_checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h4 || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL delay_capture: got v=%b req=%b addr=%h ipc=%h want 1/0/00000004/00000000",
                         instr_valid, imem_req, imem_addr, instr_pc);
    end
  endtask

  task automatic test_redirect();
    // Redirect racing an ack in WAIT.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || instr !== 32'h0) begin
      n_fail++; $display("FAIL redir_wait: got v=%b req=%b addr=%h instr=%h want 0/1/00000100/00000000",
                         instr_valid, imem_req, imem_addr, instr);
    end
    imem_rdata = mem_word(32'h100);
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redir_first: got v=%b ipc=%h instr=%h want 1/00000100/%h",
                         instr_valid, instr_pc, instr, mem_word(32'h100));
    end
    // Redirect in HOLD with ready high: squash, not a transfer.
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL redir_hold: got v=%b req=%b addr=%h want 0/1/00000040", instr_valid, imem_req, imem_addr);
    end
    // Redirect while IDLE, target at the top of the address space.
    rst = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL redir_idle: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL pc_wrap: got addr=%h ipc=%h want 00000000/fffffffc", imem_addr, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0); instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    instr_ready = 1'b0;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b req=%b addr=%h instr=%h want 0/0/00000000/00000000",
                         instr_valid, imem_req, imem_addr, instr);
    end
    rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    tick();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_addr !== 32'h4) begin
      n_fail++; $display("FAIL reset_restart: got v=%b ipc=%h addr=%h want 1/00000000/00000004",
                         instr_valid, instr_pc, imem_addr);
    end
  endtask

  // Randomized run against a transaction-level model: the model only tracks
  // whether a request is outstanding, whether a word is held, and the PC.
  task automatic test_random();
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_fetching;
    bit          m_full;
    rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    tick();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_fetching = 0; m_full = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (imem_req !== m_fetching || imem_addr !== m_pc || instr_valid !== m_full) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got req=%b addr=%h v=%b want %b/%h/%b",
                           cyc, imem_req, imem_addr, instr_valid, m_fetching, m_pc, m_full);
      end
      n_checks++;
      if (instr !== m_instr || instr_pc !== m_ipc || opcode !== m_instr[31:26] ||
          rs !== m_instr[25:21] || rt !== m_instr[20:16] || imm !== m_instr[15:0]) begin
        n_fail++; $display("FAIL rand_instr[%0d]: got %h@%h op=%h want %h@%h",
                           cyc, instr, instr_pc, opcode, m_instr, m_ipc);
      end
      rst            = ($urandom_range(0, 99) == 0);
      imem_ack       = ($urandom_range(0, 2) != 0);
      imem_rdata     = $urandom;
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      if (rst) begin
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_fetching = 0; m_full = 0;
      end else if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00}; m_full = 0; m_fetching = 1;
      end else if (!m_fetching && !m_full) begin
        m_fetching = 1;
      end else if (m_fetching && imem_ack) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        m_fetching = 0; m_full = 1;
      end else if (m_full && instr_ready) begin
        m_full = 0; m_fetching = 1;
      end
      tick();
    end
    rst = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait();
    test_lw_hold_stall();
    test_delayed_ack();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the non-pipelined MIPS CPU, directly upstream of the main control decoder.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds the returned word in an instruction register and offers it downstream with valid/ready.
- Slices out opcode and register/immediate fields; opcode drives the control unit's 6-bit opcode input.
- Accepts PC redirects (taken branches) from the execute/branch logic.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction word width; fixed MIPS format, must be 32
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_WIDTH  fetch address, always equals the PC register
imem_ack  in  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1
imem_rdata  in  DATA_WIDTH  instruction word, sampled when imem_req & imem_ack
redirect_valid  in  1  load redirect_pc into PC and squash in-flight/held work
redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] forced to 0 on load
instr_valid  out  1  instr and fields are valid for the consumer
instr_ready  in  1  consumer accepts the held instruction
instr  out  DATA_WIDTH  instruction register
instr_pc  out  ADDR_WIDTH  address the held instruction was fetched from
opcode  out  6  instr[31:26], to control unit
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]

Behaviour:
- State machine: IDLE, WAIT, HOLD. All registers are updated on clk rising edge.
- Reset (rst=1 at an edge) loads:
  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
  - Outputs after reset: imem_req=0, imem_addr=RESET_PC, all field outputs 0.
- Reset asserted mid-operation overrides everything, including a same-cycle imem_ack or redirect; the returned data is dropped.
- IDLE:
  - imem_req=0.
  - Next state WAIT unconditionally. A redirect in IDLE loads pc and still goes to WAIT.
- WAIT:
  - imem_req=1 and imem_addr=pc. imem_req stays high until ack; imem_addr may change while pending only on redirect.
  - On imem_ack with no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, next state HOLD.
  - pc wraps modulo 2^ADDR_WIDTH.
- HOLD:
  - imem_req=0 and instr_valid=1; instr and fields are stable.
  - A transfer occurs when instr_valid & instr_ready & !redirect_valid. On transfer: next state WAIT, and instr_valid=0 next cycle.
  - Without ready, HOLD persists indefinitely with no change.
- Redirect (redirect_valid=1, any state except reset):
  - pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - WAIT: a same-cycle ack is discarded (instr unchanged, pc not incremented); stay in WAIT, now requesting the new address next cycle.
  - HOLD: the held instruction is squashed; instr_valid=0 next cycle; next state WAIT. A simultaneous instr_ready does NOT count as a transfer.
- Latency and throughput:
  - With an ack in the first WAIT cycle, instr_valid rises 1 cycle after the ack edge.
  - Steady throughput is 1 instruction per 2 cycles with a zero-wait memory and ready held high.
- Field outputs are pure combinational slices of the instr register; they change only when instr changes.
- instr_valid, imem_req and pc are registered, so there are no combinational paths from inputs to them.

Test Plan:
- Reset then zero-wait memory, ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle; instr_pc matches each address.
- Memory returns 0x8C22_0010 (lw) -> opcode=6'b100011, rs=1, rt=2, imm=16'h0010, instr_valid=1 until ready.
- ack delayed 3 cycles -> imem_req high for 4 consecutive cycles, address stable, pc advances only once.
- instr_ready held 0 for 5 cycles in HOLD -> instr constant, imem_req=0 throughout, no pc change.
- redirect_valid with redirect_pc=0x0000_0103 in the same cycle as ack -> data discarded, next imem_addr=0x100, first delivered instr_pc=0x100.
- rst asserted while in WAIT with ack=1 -> next cycle instr_valid=0, imem_addr=RESET_PC, state IDLE, then fetch restarts at RESET_PC.
